ex_mem_flag_stage: RTL

//  EX->MEM pipeline stage directly downstream of the 64-bit ALU. Registers the ALU result and
//  MEM/WB control, keeps the architectural NZCV flag register, and resolves CBZ/CBNZ/B/B.cond.
//  The registered taken/target pair redirects fetch; the hazard unit flushes younger instructions.

---
 rtl/proc_pkg.sv | 30 +++
 rtl/ex_mem_flag_stage_if.sv | 50 +++++
 rtl/cond_eval.sv | 36 +++
 rtl/ex_mem_flag_stage.sv | 68 ++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor types for the EX->MEM stage: branch kinds, condition codes, NZCV flags.
package proc_pkg;

    localparam int DW = 64;
    localparam int RW = 5;

    typedef enum logic [2:0] {
        BR_NONE   = 3'd0,
        BR_UNCOND = 3'd1,
        BR_CBZ    = 3'd2,
        BR_CBNZ   = 3'd3,
        BR_BCOND  = 3'd4
    } br_type_e;

    // ARMv8 encoding order, so ex_cond can be taken straight from the instruction
    typedef enum logic [3:0] {
        COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_HS = 4'd2,  COND_LO = 4'd3,
        COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
        COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
        COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/ex_mem_flag_stage_if.sv
// EX-side inputs and MEM-side registered outputs of the EX->MEM flag stage.
interface ex_mem_flag_stage_if
    import proc_pkg::*;
();
    logic          stall;
    logic          flush;
    logic          ex_valid;
    logic [DW-1:0] alu_result;
    logic          alu_neg;
    logic          alu_zero;
    logic          alu_ovf;
    logic          alu_cout;
    logic          ex_set_flags;
    logic [2:0]    ex_br_type;
    logic [3:0]    ex_cond;
    logic [DW-1:0] ex_br_target;
    logic [DW-1:0] ex_store_data;
    logic [RW-1:0] ex_rd;
    logic          ex_mem_rd;
    logic          ex_mem_wr;
    logic          ex_reg_wr;

    logic          mem_valid;
    logic [DW-1:0] mem_result;
    logic [DW-1:0] mem_store_data;
    logic [RW-1:0] mem_rd;
    logic          mem_mem_rd;
    logic          mem_mem_wr;
    logic          mem_reg_wr;
    logic [3:0]    flags_q;
    logic          br_taken;
    logic [DW-1:0] br_target;

    modport master (
        output stall, flush, ex_valid, alu_result, alu_neg, alu_zero, alu_ovf, alu_cout,
               ex_set_flags, ex_br_type, ex_cond, ex_br_target, ex_store_data, ex_rd,
               ex_mem_rd, ex_mem_wr, ex_reg_wr,
        input  mem_valid, mem_result, mem_store_data, mem_rd, mem_mem_rd, mem_mem_wr,
               mem_reg_wr, flags_q, br_taken, br_target
    );

    modport slave (
        input  stall, flush, ex_valid, alu_result, alu_neg, alu_zero, alu_ovf, alu_cout,
               ex_set_flags, ex_br_type, ex_cond, ex_br_target, ex_store_data, ex_rd,
               ex_mem_rd, ex_mem_wr, ex_reg_wr,
        output mem_valid, mem_result, mem_store_data, mem_rd, mem_mem_rd, mem_mem_wr,
               mem_reg_wr, flags_q, br_taken, br_target
    );

endinterface

// File: rtl/cond_eval.sv
// Combinational B.cond evaluator: condition code and NZCV flags to taken.
module cond_eval
    import proc_pkg::*;
(
    input  cond_e  cond,
    input  flags_t flags,
    output logic   taken
);

    logic ge;
    logic hi;

    always_comb begin
        ge    = (flags.n == flags.v);
        hi    = flags.c & ~flags.z;
        taken = 1'b1;
        case (cond)
            COND_EQ: taken = flags.z;
            COND_NE: taken = ~flags.z;
            COND_HS: taken = flags.c;
            COND_LO: taken = ~flags.c;
            COND_MI: taken = flags.n;
            COND_PL: taken = ~flags.n;
            COND_VS: taken = flags.v;
            COND_VC: taken = ~flags.v;
            COND_HI: taken = hi;
            COND_LS: taken = ~hi;
            COND_GE: taken = ge;
            COND_LT: taken = ~ge;
            COND_GT: taken = ~flags.z & ge;
            COND_LE: taken = ~(~flags.z & ge);
            default: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX->MEM pipeline register with the NZCV flag register and branch resolution.
module ex_mem_flag_stage
    import proc_pkg::*;
(
    input logic               clk,
    input logic               reset,
    ex_mem_flag_stage_if.slave bus
);

    flags_t flags_r;
    flags_t flags_next;
    logic   capture;
    logic   bcond_taken;
    logic   br_cond;

    cond_eval u_cond_eval (
        .cond  (cond_e'(bus.ex_cond)),
        .flags (flags_r),
        .taken (bcond_taken)
    );

    // B.cond reads flags_r before this edge's write, which already holds any older setter's result
    always_comb begin
        capture    = bus.ex_valid & ~bus.flush & ~bus.stall;
        flags_next = flags_r;
        if (capture & bus.ex_set_flags)
            flags_next = '{n: bus.alu_neg, z: bus.alu_zero, c: bus.alu_cout, v: bus.alu_ovf};
        case (br_type_e'(bus.ex_br_type))
            BR_UNCOND: br_cond = 1'b1;
            BR_CBZ:    br_cond = bus.alu_zero;
            BR_CBNZ:   br_cond = ~bus.alu_zero;
            BR_BCOND:  br_cond = bcond_taken;
            default:   br_cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.mem_valid      <= 1'b0;
            bus.mem_result     <= '0;
            bus.mem_store_data <= '0;
            bus.mem_rd         <= '0;
            bus.mem_mem_rd     <= 1'b0;
            bus.mem_mem_wr     <= 1'b0;
            bus.mem_reg_wr     <= 1'b0;
            bus.br_taken       <= 1'b0;
            bus.br_target      <= '0;
            flags_r            <= '0;
        end else if (!bus.stall) begin
            bus.mem_valid  <= capture;
            bus.mem_mem_rd <= capture & bus.ex_mem_rd;
            bus.mem_mem_wr <= capture & bus.ex_mem_wr;
            bus.mem_reg_wr <= capture & bus.ex_reg_wr;
            bus.br_taken   <= capture & br_cond;
            flags_r        <= flags_next;
            // Data fields of a bubble are never consumed, so they simply keep the last value
            if (capture) begin
                bus.mem_result     <= bus.alu_result;
                bus.mem_store_data <= bus.ex_store_data;
                bus.mem_rd         <= bus.ex_rd;
                bus.br_target      <= bus.ex_br_target;
            end
        end
    end

    assign bus.flags_q = flags_r;

endmodule
